wb_gpio: RTL and testbench

Parametrised Wishbone-slave GPIO port: successor to the byte-wide I/O bridge, generalised to DSIZE pins with per-pin direction, atomic set/clear, input synchronisation and edge-triggered interrupts. Sits on the SoC Wishbone bus as a peripheral slave. Drives a bidirectional pad bus toward the chip top and raises one level interrupt to the core.

---
 rtl/wb_gpio.sv | 134 +++++++++++++
 tb/tb_wb_gpio.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone-slave GPIO with per-pin direction, atomic set/clear, input
// synchronisation and optional edge interrupts (enabled by defining WB_GPIO_IRQ_EN).
module wb_gpio #(
  parameter int               DSIZE       = 8,
  parameter int               ASIZE       = 3,
  parameter int               SYNC_STAGES = 2,
  parameter logic [DSIZE-1:0] DIR_RST     = {DSIZE{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [ASIZE-1:0] i_adr,
  input  logic             i_stb,
  input  logic             i_we,
  input  logic [DSIZE-1:0] i_dat,
  output logic             o_ack,
  output logic [DSIZE-1:0] o_dat,
  inout  wire  [DSIZE-1:0] o_iobuf,
  output logic             o_irq
);

  typedef enum logic {WB_IDLE, WB_ACK} wb_state_t;

  wb_state_t        state_reg, state_next;
  logic             start, wr, rd;
  logic [2:0]       reg_adr;
  logic [DSIZE-1:0] out_reg, dir_reg, in_val, rd_data;
  logic [DSIZE-1:0] sync_reg [SYNC_STAGES];

  assign reg_adr = i_adr[2:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_reg <= WB_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WB_IDLE: if (i_stb) state_next = WB_ACK;
      WB_ACK:  state_next = WB_IDLE;
      default: state_next = WB_IDLE;
    endcase
  end

  always_comb begin
    o_ack = (state_reg == WB_ACK);
    start = (state_reg == WB_IDLE) && i_stb;
    wr    = start && i_we;
    rd    = start && !i_we;
  end

  genvar gi;

  // Pads are released (tristated) whenever the pin is configured as input.
  for (gi = 0; gi < DSIZE; gi++) begin : g_pad
    assign o_iobuf[gi] = dir_reg[gi] ? 1'bz : out_reg[gi];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_reg[0] <= '0;
    else       sync_reg[0] <= o_iobuf;
  end

  for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) sync_reg[gi] <= '0;
      else       sync_reg[gi] <= sync_reg[gi-1];
    end
  end

  assign in_val = sync_reg[SYNC_STAGES-1];

`ifdef WB_GPIO_IRQ_EN
  logic [DSIZE-1:0] prev_reg, irq_en_reg, irq_edge_reg, irq_stat_reg;
  logic [DSIZE-1:0] edge_hit, stat_clr;

  assign edge_hit = dir_reg & (in_val ^ prev_reg) & ~(in_val ^ irq_edge_reg);
  assign stat_clr = (wr && reg_adr == 3'd7) ? i_dat : '0;

  // A new edge in the same cycle as its W1C clear keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_reg     <= '0;
      irq_en_reg   <= '0;
      irq_edge_reg <= '0;
      irq_stat_reg <= '0;
      o_irq        <= 1'b0;
    end else begin
      prev_reg     <= in_val;
      irq_stat_reg <= (irq_stat_reg & ~stat_clr) | edge_hit;
      o_irq        <= |(irq_stat_reg & irq_en_reg);
      if (wr && reg_adr == 3'd5) irq_en_reg   <= i_dat;
      if (wr && reg_adr == 3'd6) irq_edge_reg <= i_dat;
    end
  end
`else
  assign o_irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_adr)
      3'd0: rd_data = in_val;
      3'd1: rd_data = out_reg;
      3'd2: rd_data = dir_reg;
`ifdef WB_GPIO_IRQ_EN
      3'd5: rd_data = irq_en_reg;
      3'd6: rd_data = irq_edge_reg;
      3'd7: rd_data = irq_stat_reg;
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_reg <= '0;
      dir_reg <= DIR_RST;
      o_dat   <= '0;
    end else begin
      if (wr) begin
        case (reg_adr)
          3'd1:    out_reg <= i_dat;
          3'd2:    dir_reg <= i_dat;
          3'd3:    out_reg <= out_reg | i_dat;
          3'd4:    out_reg <= out_reg & ~i_dat;
          default: ;
        endcase
      end
      if (rd) o_dat <= rd_data;
    end
  end

endmodule

// File: tb/tb_wb_gpio.sv
// Directed self-checking bench for wb_gpio (DSIZE=8, SYNC_STAGES=2);
// interrupt or macro-off scenarios are chosen by WB_GPIO_IRQ_EN.
module tb_wb_gpio;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [2:0] i_adr;
  logic       i_stb;
  logic       i_we;
  logic [7:0] i_dat;
  logic       o_ack;
  logic [7:0] o_dat;
  logic       o_irq;
  wire  [7:0] pads;
  logic [7:0] pad_val, pad_en;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 8; gi++) begin : g_tbpad
    assign pads[gi] = pad_en[gi] ? pad_val[gi] : 1'bz;
  end

  wb_gpio #(.DSIZE(8), .ASIZE(3), .SYNC_STAGES(2), .DIR_RST(8'hFF)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_adr(i_adr), .i_stb(i_stb), .i_we(i_we),
    .i_dat(i_dat), .o_ack(o_ack), .o_dat(o_dat), .o_iobuf(pads), .o_irq(o_irq)
  );

  // Both bus tasks are entered 1 time unit after a rising edge.
  task automatic wb_write(input logic [2:0] adr, input logic [7:0] dat);
    i_adr = adr; i_we = 1'b1; i_dat = dat; i_stb = 1'b1;
    @(posedge clk); #1;
    i_stb = 1'b0; i_we = 1'b0;
    @(posedge clk); #1;
    $display("[TB] write adr=%0d dat=%02h", adr, dat);
  endtask

  task automatic wb_read(input logic [2:0] adr, output logic [7:0] dat,
                         output logic ack_a, output logic ack_b);
    i_adr = adr; i_we = 1'b0; i_stb = 1'b1;
    @(posedge clk); #1;
    ack_a = o_ack; dat = o_dat; i_stb = 1'b0;
    @(posedge clk); #1;
    ack_b = o_ack;
    $display("[TB] read  adr=%0d dat=%02h ack=%0b%0b", adr, dat, ack_a, ack_b);
  endtask

  task automatic test_reset();
    logic [7:0] d; logic a0, a1;
    pad_en = 8'h00; pad_val = 8'h00;
    wb_write(3'd2, 8'h00);
    wb_write(3'd1, 8'h12);
    wb_read(3'd1, d, a0, a1);
    tests_run++; if (d !== 8'h12) begin tests_failed++; $display("FAIL pre_reset_out got=%02h exp=12", d); end
    i_adr = 3'd1; i_we = 1'b1; i_dat = 8'h77; i_stb = 1'b1;
    @(posedge clk); #3;
    i_rst = 1'b1; #1;
    tests_run++; if (o_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got=%0b exp=0", o_ack); end
    tests_run++; if (o_dat !== 8'h00) begin tests_failed++; $display("FAIL reset_dat got=%02h exp=00", o_dat); end
    tests_run++; if (o_irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq got=%0b exp=0", o_irq); end
    i_stb = 1'b0; i_we = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    i_rst = 1'b0;
    wb_read(3'd1, d, a0, a1);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_out got=%02h exp=00", d); end
    wb_read(3'd2, d, a0, a1);
    tests_run++; if (d !== 8'hFF) begin tests_failed++; $display("FAIL reset_dir got=%02h exp=FF", d); end
    pad_en = 8'hFF; pad_val = 8'h5A;
    repeat (3) @(posedge clk); #1;
    wb_read(3'd0, d, a0, a1);
    tests_run++; if (d !== 8'h5A) begin tests_failed++; $display("FAIL reset_pads_released got=%02h exp=5A", d); end
  endtask

  task automatic test_output();
    logic [7:0] d; logic a0, a1;
    pad_en = 8'h00;
    wb_write(3'd2, 8'h00);
    wb_write(3'd1, 8'hA5);
    tests_run++; if (pads !== 8'hA5) begin tests_failed++; $display("FAIL out_pads got=%02h exp=A5", pads); end
    wb_read(3'd1, d, a0, a1);
    tests_run++; if (d !== 8'hA5) begin tests_failed++; $display("FAIL out_read got=%02h exp=A5", d); end
    tests_run++; if (a0 !== 1'b1) begin tests_failed++; $display("FAIL out_ack_first got=%0b exp=1", a0); end
    tests_run++; if (a1 !== 1'b0) begin tests_failed++; $display("FAIL out_ack_second got=%0b exp=0", a1); end
    wb_read(3'd2, d, a0, a1);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL dir_read got=%02h exp=00", d); end
  endtask

  task automatic test_set_clr();
    logic [7:0] d; logic a0, a1;
    wb_write(3'd1, 8'hA5);
    wb_write(3'd3, 8'h0F);
    wb_read(3'd1, d, a0, a1);
    tests_run++; if (d !== 8'hAF) begin tests_failed++; $display("FAIL out_set got=%02h exp=AF", d); end
    wb_write(3'd4, 8'hA0);
    wb_read(3'd1, d, a0, a1);
    tests_run++; if (d !== 8'h0F) begin tests_failed++; $display("FAIL out_clr got=%02h exp=0F", d); end
    tests_run++; if (pads !== 8'h0F) begin tests_failed++; $display("FAIL clr_pads got=%02h exp=0F", pads); end
    wb_read(3'd3, d, a0, a1);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL set_reads0 got=%02h exp=00", d); end
    wb_read(3'd4, d, a0, a1);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL clr_reads0 got=%02h exp=00", d); end
  endtask

  task automatic test_input_sync();
    logic [7:0] d; logic a0, a1;
    wb_write(3'd2, 8'hFF);
    wb_write(3'd0, 8'hEE);
    pad_en = 8'hFF; pad_val = 8'h00;
    repeat (4) @(posedge clk); #1;
    // Change before edge M; a read sampled at M+1 must still see the old value.
    pad_val = 8'h3C;
    @(posedge clk); #1;
    wb_read(3'd0, d, a0, a1);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL in_too_early got=%02h exp=00", d); end
    wb_read(3'd0, d, a0, a1);
    tests_run++; if (d !== 8'h3C) begin tests_failed++; $display("FAIL in_settled got=%02h exp=3C", d); end
    // A read sampled at M+2 must see the new value.
    pad_val = 8'hC3;
    @(posedge clk); @(posedge clk); #1;
    wb_read(3'd0, d, a0, a1);
    tests_run++; if (d !== 8'hC3) begin tests_failed++; $display("FAIL in_latency got=%02h exp=C3", d); end
    pad_en = 8'hF0; pad_val = 8'h30;
    wb_write(3'd1, 8'h05);
    wb_write(3'd2, 8'hF0);
    repeat (3) @(posedge clk); #1;
    wb_read(3'd0, d, a0, a1);
    tests_run++; if (d !== 8'h35) begin tests_failed++; $display("FAIL in_mixed got=%02h exp=35", d); end
  endtask

`ifdef WB_GPIO_IRQ_EN
  task automatic test_irq();
    logic [7:0] d; logic a0, a1;
    wb_write(3'd2, 8'hFF);
    pad_en = 8'hFF; pad_val = 8'h00;
    repeat (4) @(posedge clk); #1;
    wb_write(3'd6, 8'h03);
    wb_write(3'd7, 8'hFF);
    wb_write(3'd5, 8'h01);
    wb_read(3'd7, d, a0, a1);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL irq_stat_idle got=%02h exp=00", d); end
    pad_val = 8'h01;
    repeat (3) @(posedge clk); #1;
    tests_run++; if (o_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_early got=%0b exp=0", o_irq); end
    @(posedge clk); #1;
    tests_run++; if (o_irq !== 1'b1) begin tests_failed++; $display("FAIL irq_rise got=%0b exp=1", o_irq); end
    wb_read(3'd7, d, a0, a1);
    tests_run++; if (d !== 8'h01) begin tests_failed++; $display("FAIL irq_stat_pin0 got=%02h exp=01", d); end
    pad_val = 8'h03;
    repeat (4) @(posedge clk); #1;
    wb_read(3'd7, d, a0, a1);
    tests_run++; if (d !== 8'h03) begin tests_failed++; $display("FAIL irq_stat_pin1 got=%02h exp=03", d); end
    wb_write(3'd7, 8'h03);
    tests_run++; if (o_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_w1c got=%0b exp=0", o_irq); end
    pad_val = 8'h02;
    repeat (4) @(posedge clk); #1;
    wb_read(3'd7, d, a0, a1);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL irq_falling_ignored got=%02h exp=00", d); end
    tests_run++; if (o_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_falling_level got=%0b exp=0", o_irq); end
    pad_val = 8'h03;
    repeat (4) @(posedge clk); #1;
    pad_val = 8'h02;
    repeat (4) @(posedge clk); #1;
    // Rising edge before M sets STAT at M+2, exactly when this W1C is sampled.
    pad_val = 8'h03;
    @(posedge clk); @(posedge clk); #1;
    wb_write(3'd7, 8'h01);
    wb_read(3'd7, d, a0, a1);
    tests_run++; if (d !== 8'h01) begin tests_failed++; $display("FAIL irq_set_wins got=%02h exp=01", d); end
    tests_run++; if (o_irq !== 1'b1) begin tests_failed++; $display("FAIL irq_set_wins_level got=%0b exp=1", o_irq); end
  endtask
`else
  task automatic test_macro_off();
    logic [7:0] d; logic a0, a1;
    wb_write(3'd2, 8'hFF);
    pad_en = 8'hFF; pad_val = 8'h00;
    wb_write(3'd5, 8'hFF);
    wb_write(3'd6, 8'hFF);
    wb_write(3'd7, 8'hFF);
    repeat (3) @(posedge clk); #1;
    pad_val = 8'hFF;
    repeat (4) @(posedge clk); #1;
    tests_run++; if (o_irq !== 1'b0) begin tests_failed++; $display("FAIL off_irq_rise got=%0b exp=0", o_irq); end
    pad_val = 8'h00;
    repeat (4) @(posedge clk); #1;
    tests_run++; if (o_irq !== 1'b0) begin tests_failed++; $display("FAIL off_irq_fall got=%0b exp=0", o_irq); end
    wb_read(3'd5, d, a0, a1);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL off_adr5 got=%02h exp=00", d); end
    wb_read(3'd6, d, a0, a1);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL off_adr6 got=%02h exp=00", d); end
    wb_read(3'd7, d, a0, a1);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL off_adr7 got=%02h exp=00", d); end
  endtask
`endif

  initial begin
    i_rst = 1'b1; i_adr = 3'd0; i_stb = 1'b0; i_we = 1'b0; i_dat = 8'h00;
    pad_en = 8'h00; pad_val = 8'h00;
    repeat (2) @(posedge clk); #1;
    i_rst = 1'b0;
    test_reset();
    test_output();
    test_set_clr();
    test_input_sync();
`ifdef WB_GPIO_IRQ_EN
    test_irq();
`else
    test_macro_off();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
